gcd_arbiter: RTL

- Shares one GCD datapath unit among NUM_REQ independent requesters.
- Uses round-robin arbitration and keeps one operation in flight at a time.
- Each requester has a valid/ready request channel and a valid/ready response channel.
- Sits between the requesters and the GCD unit's reset/x/y/in_valid/in_ready/out/out_valid/busy interface. Adds a watchdog that reports a hung GCD operation as an error response.

---
 rtl/gcd_arbiter.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/gcd_arbiter.sv
// Round-robin arbiter that shares one GCD unit among NUM_REQ requesters, one operation
// in flight, with a watchdog that turns a hung GCD operation into an error response.
//
// state  | meaning
// IDLE   | searching for the next requester after 'last'; grant accepted combinationally
// ISSUE  | presenting latched operands to the GCD unit until it accepts them
// WAIT   | counting cycles until a fresh result arrives or the watchdog expires
// RESP   | holding the response for the granted requester until it is taken
module gcd_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int W       = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*W-1:0]       req_x,
    input  logic [NUM_REQ*W-1:0]       req_y,
    output logic [NUM_REQ-1:0]         resp_valid,
    input  logic [NUM_REQ-1:0]         resp_ready,
    output logic [W-1:0]               resp_data,
    output logic                       resp_err,
    output logic [W-1:0]               gcd_x,
    output logic [W-1:0]               gcd_y,
    output logic                       gcd_in_valid,
    input  logic                       gcd_in_ready,
    input  logic [W-1:0]               gcd_out,
    input  logic                       gcd_out_valid,
    input  logic                       gcd_busy,
    output logic                       gcd_reset,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   last_q;
    logic [IW-1:0]   pick;
    logic [IW-1:0]   cand;
    logic            found;
    logic [W-1:0]    op_x_q, op_y_q, result_q;
    logic            err_q;
    logic [CW-1:0]   cnt_q;
    logic            rst_pulse_q;
    logic            take;
    logic            timeout_hit;

    // Walk last+1, last+2, ... with wrap so non-power-of-two NUM_REQ never indexes past the end.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        cand  = last_q;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (cand == IW'(NUM_REQ - 1)) cand = '0;
            else                          cand = cand + IW'(1);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    // A zero count means out_valid may still be the previous operation's result.
    assign take        = gcd_out_valid && !gcd_busy && (cnt_q != '0);
    assign timeout_hit = (cnt_q == CW'(TIMEOUT - 1));

    always_ff @(posedge clock) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (found)                state_d = S_ISSUE;
            S_ISSUE: if (gcd_in_ready)         state_d = S_WAIT;
            S_WAIT:  if (take || timeout_hit)  state_d = S_RESP;
            S_RESP:  if (resp_ready[grant_id]) state_d = S_IDLE;
            default:                           state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready    = '0;
        resp_valid   = '0;
        gcd_in_valid = 1'b0;
        busy         = (state_q != S_IDLE);
        if (state_q == S_IDLE && found) req_ready[pick] = 1'b1;
        if (state_q == S_RESP)          resp_valid[grant_id] = 1'b1;
        if (state_q == S_ISSUE)         gcd_in_valid = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            last_q      <= IW'(NUM_REQ - 1);
            grant_id    <= '0;
            op_x_q      <= '0;
            op_y_q      <= '0;
            result_q    <= '0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
            rst_pulse_q <= 1'b1;
        end else begin
            rst_pulse_q <= 1'b0;
            case (state_q)
                S_IDLE: if (found) begin
                    op_x_q   <= req_x[W*int'(pick) +: W];
                    op_y_q   <= req_y[W*int'(pick) +: W];
                    grant_id <= pick;
                end
                S_ISSUE: if (gcd_in_ready) cnt_q <= '0;
                S_WAIT: begin
                    cnt_q <= cnt_q + CW'(1);
                    if (take) begin
                        result_q <= gcd_out;
                        err_q    <= 1'b0;
                    end else if (timeout_hit) begin
                        result_q    <= '0;
                        err_q       <= 1'b1;
                        rst_pulse_q <= 1'b1;
                    end
                end
                S_RESP: if (resp_ready[grant_id]) last_q <= grant_id;
                default: ;
            endcase
        end
    end

    assign gcd_reset = !reset || rst_pulse_q;
    assign gcd_x     = op_x_q;
    assign gcd_y     = op_y_q;
    assign resp_data = result_q;
    assign resp_err  = err_q;

endmodule
